// File: rtl/distribute_1x2_branch_buffer.sv
// Two-branch elastic buffer behind the 1x2 distribute switch, one FIFO per branch (high, low).
// Latency: a word accepted at edge N appears on o_valid/o_data_bus after edge N; there is no bypass.
// Backpressure: single o_ready drops when either FIFO is full or i_en=0. Optional DISTRIBUTE_BUF_STALL_CNT_EN adds o_stall_cnt.
module distribute_1x2_branch_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic [1:0]              i_valid,
  input  logic [2*DATA_WIDTH-1:0] i_data_bus,
  output logic                    o_ready,
  output logic [1:0]              o_valid,
  output logic [2*DATA_WIDTH-1:0] o_data_bus,
  input  logic [1:0]              i_ready
`ifdef DISTRIBUTE_BUF_STALL_CNT_EN
  ,
  output logic [31:0]             o_stall_cnt
`endif
);

  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(FIFO_DEPTH);

  logic [1:0] full;

  // A single ready covers both branches so a duplicate beat is never half-accepted.
  assign o_ready = i_en & rst_n & ~full[1] & ~full[0];

  genvar b;
  for (b = 0; b < 2; b++) begin : g_branch
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  wr;
    logic                  rd;

    assign wr = i_valid[b] & o_ready;
    assign rd = o_valid[b] & i_ready[b];

    always_ff @(posedge clk) begin
      if (wr) begin
        mem[wptr] <= i_data_bus[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (wr) begin
          wptr <= wptr + ADDR_WIDTH'(1);
        end
        if (rd) begin
          rptr <= rptr + ADDR_WIDTH'(1);
        end
        case ({wr, rd})
          2'b10:   cnt <= cnt + (ADDR_WIDTH+1)'(1);
          2'b01:   cnt <= cnt - (ADDR_WIDTH+1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    assign full[b]    = (cnt == CNT_FULL);
    assign o_valid[b] = (cnt != '0);
    // Idle branches present zero rather than stale memory contents.
    assign o_data_bus[b*DATA_WIDTH +: DATA_WIDTH] = o_valid[b] ? mem[rptr] : '0;
  end

`ifdef DISTRIBUTE_BUF_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_stall_cnt <= '0;
    end else if ((|i_valid) && !o_ready && (o_stall_cnt != 32'hFFFF_FFFF)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_distribute_1x2_branch_buffer.sv
// Bench for distribute_1x2_branch_buffer: directed vector table, corner sequences, then random
// traffic checked every cycle against a queue-based reference model.
module tb_distribute_1x2_branch_buffer;
  localparam int W = 32;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_en;
  logic [1:0]     i_valid;
  logic [2*W-1:0] i_data_bus;
  logic           o_ready;
  logic [1:0]     o_valid;
  logic [2*W-1:0] o_data_bus;
  logic [1:0]     i_ready;
`ifdef DISTRIBUTE_BUF_STALL_CNT_EN
  logic [31:0]    o_stall_cnt;
`endif

  always #5 clk = ~clk;

  distribute_1x2_branch_buffer #(.DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .i_ready    (i_ready)
`ifdef DISTRIBUTE_BUF_STALL_CNT_EN
    ,
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per branch plus a stall counter.
  logic [W-1:0] q_h[$];
  logic [W-1:0] q_l[$];
  logic [31:0]  m_stall = 32'd0;

  typedef struct {
    logic         rst_n;
    logic         en;
    logic [1:0]   valid;
    logic [W-1:0] dh;
    logic [W-1:0] dl;
    logic [1:0]   ready;
    logic         exp_ready;
    logic [1:0]   exp_valid;
    logic [W-1:0] exp_h;
    logic [W-1:0] exp_l;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, compare outputs with the model before the edge, then advance the model.
  task automatic step(input logic r, input logic en, input logic [1:0] v,
                      input logic [W-1:0] dh, input logic [W-1:0] dl, input logic [1:0] rdy,
                      output logic s_ready, output logic [1:0] s_valid, output logic [2*W-1:0] s_data);
    logic         m_ready;
    logic [1:0]   m_valid;
    logic [W-1:0] hh;
    logic [W-1:0] hl;
    @(negedge clk);
    rst_n = r; i_en = en; i_valid = v; i_data_bus = {dh, dl}; i_ready = rdy;
    #1;
    m_ready = r & en & (q_h.size() != DEPTH) & (q_l.size() != DEPTH);
    m_valid = {q_h.size() != 0, q_l.size() != 0};
    hh = (q_h.size() != 0) ? q_h[0] : '0;
    hl = (q_l.size() != 0) ? q_l[0] : '0;
    s_ready = o_ready; s_valid = o_valid; s_data = o_data_bus;
    chk("o_ready", 64'(o_ready), 64'(m_ready));
    chk("o_valid", 64'(o_valid), 64'(m_valid));
    chk("o_data_bus", o_data_bus, {hh, hl});
`ifdef DISTRIBUTE_BUF_STALL_CNT_EN
    chk("o_stall_cnt", 64'(o_stall_cnt), 64'(m_stall));
`endif
    @(posedge clk);
    if (!r) begin
      q_h.delete(); q_l.delete(); m_stall = 32'd0;
    end else begin
      if (m_valid[1] && rdy[1]) void'(q_h.pop_front());
      if (m_valid[0] && rdy[0]) void'(q_l.pop_front());
      if (m_ready && v[1]) q_h.push_back(dh);
      if (m_ready && v[0]) q_l.push_back(dl);
      if ((|v) && !m_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
    end
  endtask

  task automatic cyc(input logic r, input logic en, input logic [1:0] v,
                     input logic [W-1:0] dh, input logic [W-1:0] dl, input logic [1:0] rdy);
    logic sr; logic [1:0] sv; logic [2*W-1:0] sd;
    step(r, en, v, dh, dl, rdy, sr, sv, sd);
  endtask

  initial begin
    logic sr; logic [1:0] sv; logic [2*W-1:0] sd;
    rst_n = 1'b0; i_en = 1'b1; i_valid = 2'b00; i_data_bus = '0; i_ready = 2'b00;
    repeat (2) @(posedge clk);

    //            rst en valid dh     dl     rdy    exp_rdy exp_vld exp_h  exp_l
    tbl[0]  = '{1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 2'b11, 32'hA, 32'hB, 2'b11, 1'b1, 2'b00, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 2'b11, 1'b1, 2'b11, 32'hA, 32'hB};
    tbl[3]  = '{1'b1, 1'b1, 2'b01, 32'h0, 32'h1, 2'b00, 1'b1, 2'b00, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 2'b01, 32'h0, 32'h2, 2'b00, 1'b1, 2'b01, 32'h0, 32'h1};
    tbl[5]  = '{1'b1, 1'b1, 2'b01, 32'h0, 32'h3, 2'b00, 1'b1, 2'b01, 32'h0, 32'h1};
    tbl[6]  = '{1'b1, 1'b1, 2'b01, 32'h0, 32'h4, 2'b00, 1'b1, 2'b01, 32'h0, 32'h1};
    tbl[7]  = '{1'b1, 1'b1, 2'b01, 32'h0, 32'h5, 2'b00, 1'b0, 2'b01, 32'h0, 32'h1};
    tbl[8]  = '{1'b1, 1'b1, 2'b10, 32'h9, 32'h0, 2'b00, 1'b0, 2'b01, 32'h0, 32'h1};
    tbl[9]  = '{1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 2'b01, 1'b0, 2'b01, 32'h0, 32'h1};
    tbl[10] = '{1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 2'b01, 1'b1, 2'b01, 32'h0, 32'h2};
    tbl[11] = '{1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 2'b11, 1'b1, 2'b01, 32'h0, 32'h3};
    tbl[12] = '{1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 2'b01, 1'b1, 2'b01, 32'h0, 32'h4};
    tbl[13] = '{1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 2'b11, 1'b1, 2'b00, 32'h0, 32'h0};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst_n, tbl[i].en, tbl[i].valid, tbl[i].dh, tbl[i].dl, tbl[i].ready, sr, sv, sd);
      chk($sformatf("tbl%0d_ready", i), 64'(sr), 64'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_valid", i), 64'(sv), 64'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_data", i), sd, {tbl[i].exp_h, tbl[i].exp_l});
    end

    // Steady duplicate traffic: one word per branch per cycle, pointers wrap several times.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 2'b11, $urandom, $urandom, 2'b11);
    end
    cyc(1'b1, 1'b1, 2'b00, '0, '0, 2'b11);

    // Half-full FIFOs discarded by a one-cycle reset; nothing old may reappear.
    cyc(1'b1, 1'b1, 2'b11, 32'hDEAD_0001, 32'hBEEF_0001, 2'b00);
    cyc(1'b1, 1'b1, 2'b11, 32'hDEAD_0002, 32'hBEEF_0002, 2'b00);
    cyc(1'b0, 1'b1, 2'b00, '0, '0, 2'b00);
    step(1'b1, 1'b1, 2'b00, '0, '0, 2'b11, sr, sv, sd);
    chk("post_reset_ready", 64'(sr), 64'd1);
    chk("post_reset_valid", 64'(sv), 64'd0);
    chk("post_reset_data", sd, 64'd0);
    cyc(1'b1, 1'b1, 2'b11, 32'h1111, 32'h2222, 2'b11);
    cyc(1'b1, 1'b1, 2'b00, '0, '0, 2'b11);

    // Disable with words queued: no acceptance, queued words still drain.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2'b11, 32'h300 + i, 32'h400 + i, 2'b00);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 2'b11, 32'hBAD, 32'hBAD, 2'b11);
    step(1'b1, 1'b0, 2'b00, '0, '0, 2'b11, sr, sv, sd);
    chk("disabled_drained_valid", 64'(sv), 64'd0);
    chk("disabled_ready", 64'(sr), 64'd0);

    // Randomized traffic against the model, with occasional resets and disables.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) != 0), 2'($urandom),
          $urandom, $urandom, 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion before 200000");
    $fatal(1);
  end
endmodule
